// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: decodes the MEM instruction, runs a req/ack
// data-memory transaction, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IR_M,
  input  logic [31:0] ALU_M,
  input  logic [31:0] RT_M,
  output logic [31:0] DM,
  output logic        stall,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  count;
  logic [5:0]  op_reg;
  logic [1:0]  lane_reg;
  logic        is_load_reg;

  logic [5:0]  opcode;
  logic        is_load, is_store, misaligned, go, timeout;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        unused_ir;

  assign opcode    = IR_M[31:26];
  assign unused_ir = ^IR_M[25:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = RT_M;
    case (opcode)
      6'h20, 6'h24: is_load = 1'b1;
      6'h21, 6'h25: begin
        is_load    = 1'b1;
        misaligned = ALU_M[0];
      end
      6'h23: begin
        is_load    = 1'b1;
        misaligned = |ALU_M[1:0];
      end
      6'h28: begin
        is_store   = 1'b1;
        be_next    = 4'b0001 << ALU_M[1:0];
        wdata_next = {4{RT_M[7:0]}};
      end
      6'h29: begin
        is_store   = 1'b1;
        misaligned = ALU_M[0];
        be_next    = ALU_M[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{RT_M[15:0]}};
      end
      6'h2B: begin
        is_store   = 1'b1;
        misaligned = |ALU_M[1:0];
      end
      default: ;
    endcase
  end

  assign go       = (state == IDLE) && (is_load || is_store) && !misaligned;
  assign addr_err = (state == IDLE) && (is_load || is_store) && misaligned;
  assign stall    = go || (state == WAIT);
  assign timeout  = (count == 8'(MAX_WAIT - 1));

  // Lane selection uses the address captured at issue, not the live ALU_M.
  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (lane_reg)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: byte_sel = mem_rdata[7:0];
    endcase
    half_sel = lane_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_reg)
      6'h20:   load_data = {{24{byte_sel[7]}}, byte_sel};
      6'h24:   load_data = {24'd0, byte_sel};
      6'h21:   load_data = {{16{half_sel[15]}}, half_sel};
      6'h25:   load_data = {16'd0, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = WAIT;
      WAIT:    if (mem_ack || timeout) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 8'd0;
      DM          <= 32'd0;
      bus_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      op_reg      <= 6'd0;
      lane_reg    <= 2'd0;
      is_load_reg <= 1'b0;
    end else begin
      state   <= state_next;
      bus_err <= 1'b0;
      case (state)
        IDLE: if (go) begin
          mem_req     <= 1'b1;
          mem_we      <= is_store;
          mem_be      <= be_next;
          mem_addr    <= {ALU_M[31:2], 2'b00};
          mem_wdata   <= wdata_next;
          count       <= 8'd0;
          op_reg      <= opcode;
          lane_reg    <= ALU_M[1:0];
          is_load_reg <= is_load;
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load_reg) DM <= load_data;
          end else if (timeout) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            if (is_load_reg) DM <= 32'd0;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
